// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MduWidth = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_DIVU  = 2'b01
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add for MULTU, restoring
// shift-subtract for DIVU. Purely combinational.
// Build option: MDU_DIV_EN includes the subtract/borrow path.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned Width = MduWidth
) (
    input  mdu_op_e          op_i,
    input  logic [Width-1:0] hi_i,
    input  logic [Width-1:0] lo_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    logic [Width:0] sum;
`ifdef MDU_DIV_EN
    logic [Width:0] diff;
`else
    logic unused_op;
    assign unused_op = ^op_i;
`endif

    // Select add or subtract result and form the shifted hi/lo pair
    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        hi_o = sum[Width:1];
        lo_o = {sum[0], lo_i[Width-1:1]};
`ifdef MDU_DIV_EN
        diff = {hi_i, lo_i[Width-1]} - {1'b0, b_i};
        if (op_i == MDU_DIVU) begin
            if (!diff[Width]) begin
                // No borrow: keep the difference, quotient bit is 1
                hi_o = diff[Width-1:0];
                lo_o = {lo_i[Width-2:0], 1'b1};
            end else begin
                // Borrow: restore by just shifting, quotient bit is 0
                hi_o = {hi_i[Width-2:0], lo_i[Width-1]};
                lo_o = {lo_i[Width-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply/divide unit feeding the HI/LO registers.
// Runs Width single-step iterations through mdu_step with a
// start/busy/done handshake.
// Build option: MDU_DIV_EN enables DIVU; without it op 2'b01 is ignored
// and div_zero_o is tied low.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned Width = MduWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    logic [Width-1:0] b_q, b_d;
    logic [Width-1:0] hi_q, hi_d;
    logic [Width-1:0] lo_q, lo_d;
    logic [Width-1:0] hi_res_q, hi_res_d;
    logic [Width-1:0] lo_res_q, lo_res_d;
    logic             done_q, done_d;
    logic             op_ok;
    logic [Width-1:0] step_hi, step_lo;
`ifdef MDU_DIV_EN
    logic             dz_q, dz_d;
`endif

    mdu_step #(
        .Width (Width)
    ) u_step (
        .op_i  (op_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .b_i   (b_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    // Which op codes this build accepts
    always_comb begin
`ifdef MDU_DIV_EN
        op_ok = (op_i == MDU_MULTU) || (op_i == MDU_DIVU);
`else
        op_ok = (op_i == MDU_MULTU);
`endif
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_res_d = hi_res_q;
        lo_res_d = lo_res_q;
        done_d   = 1'b0;
`ifdef MDU_DIV_EN
        dz_d     = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i && op_ok) begin
                    op_d    = mdu_op_e'(op_i);
                    b_d     = b_i;
                    hi_d    = '0;
                    lo_d    = a_i;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Width - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Results and done pulse are registered together as DONE retires
                hi_res_d = hi_q;
                lo_res_d = lo_q;
`ifdef MDU_DIV_EN
                dz_d     = (op_q == MDU_DIVU) && (b_q == '0);
`endif
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, asynchronously cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MDU_MULTU;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_res_q <= '0;
            lo_res_q <= '0;
            done_q   <= 1'b0;
`ifdef MDU_DIV_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_res_q <= hi_res_d;
            lo_res_q <= lo_res_d;
            done_q   <= done_d;
`ifdef MDU_DIV_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = done_q;
    assign hi_o   = hi_res_q;
    assign lo_o   = lo_res_q;
`ifdef MDU_DIV_EN
    assign div_zero_o = dz_q;
`else
    assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected results are queued at start and
// compared when done_o pulses, together with latency and busy length.
module tb_mdu_seq;

    localparam int unsigned Width = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [Width-1:0] a = '0;
    logic [Width-1:0] b = '0;
    logic             busy, done, div_zero;
    logic [Width-1:0] hi, lo;

    mdu_seq #(
        .Width (Width)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo),
        .div_zero_o (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [Width-1:0] hi;
        logic [Width-1:0] lo;
        logic             dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts busy cycles and scores each completion
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("latency", 64'(cyc - accept_cyc), 64'(Width + 1));
                check("busy_len", 64'(busy_cnt), 64'(Width));
            end
        end
    end

    function automatic exp_t model(input logic [1:0] o, input logic [Width-1:0] x,
                                   input logic [Width-1:0] y);
        exp_t   e;
        logic [63:0] p;
        if (o == 2'b00) begin
            p    = 64'(x) * 64'(y);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (y == '0) begin
            e.hi = x;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive one start for a single cycle; returns at the negedge after it
    task automatic start_op(input logic [1:0] o, input logic [Width-1:0] x,
                            input logic [Width-1:0] y, input bit expect_accept);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (expect_accept) begin
            sb.push_back(model(o, x, y));
            busy_cnt   = 0;
            accept_cyc = cyc + 1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        for (int i = 0; i < 3 * Width; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-range multiply
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mul_max");
        check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("mul_max_lo", 64'(lo), 64'h0000_0001);

        // Small multiply then hold with no start
        start_op(2'b00, 32'd3, 32'd5, 1'b1);
        wait_done("mul_small");
        repeat (10) @(negedge clk);
        check("hold_hi", 64'(hi), 64'd0);
        check("hold_lo", 64'(lo), 64'd15);
        check("hold_dz", 64'(div_zero), 64'd0);
        check("hold_done", 64'(done), 64'd0);

`ifdef MDU_DIV_EN
        start_op(2'b01, 32'd100, 32'd7, 1'b1);
        wait_done("div");
        start_op(2'b01, 32'h1234_5678, 32'd0, 1'b1);
        wait_done("div0");
        check("div0_held", 64'(div_zero), 64'd1);
        start_op(2'b01, 32'hDEAD_BEEF, 32'h0001_0003, 1'b1);
        wait_done("div_big");
        start_op(2'b00, 32'd1, 32'd1, 1'b1);
        wait_done("mul_after_div");
`else
        // DIVU not built: start must be ignored
        seen = 0;
        start_op(2'b01, 32'h1234_5678, 32'd0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("divu_ignored_busy", 64'(seen), 64'd0);
        check("divu_ignored_lo", 64'(lo), 64'd15);
`endif

        // Start during CALC is ignored and not queued
        d0 = done_cnt;
        start_op(2'b00, 32'd6, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("mul_busy_start");
        repeat (2 * Width) @(negedge clk);
        check("one_done", 64'(done_cnt - d0), 64'd1);
        check("mul67_lo", 64'(lo), 64'd42);

        // Reserved op in IDLE
        seen = 0;
        start_op(2'b11, 32'd5, 32'd5, 1'b0);
        repeat (5) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("reserved_busy", 64'(seen), 64'd0);
        check("reserved_lo", 64'(lo), 64'd42);

        // Asynchronous reset mid-CALC
        d0 = done_cnt;
        start_op(2'b00, 32'h0001_2345, 32'h0000_6789, 1'b0);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_hi", 64'(hi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * Width) @(negedge clk);
        check("no_done_after_rst", 64'(done_cnt - d0), 64'd0);

        start_op(2'b00, 32'd2, 32'd2, 1'b1);
        wait_done("mul_after_rst");
        check("mul22_lo", 64'(lo), 64'd4);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
